psg_audio_mixer: RTL and testbench
==================================

// Module: psg_audio_mixer
// PURPOSE
//  Downstream of the YM2149/AY PSG core. Consumes the three 8-bit channel levels (CHANNEL_A/B/C),
//  maps them to stereo (mono/ABC/ACB) and box-filter decimates over DECIM PSG clock-enable ticks.
//  Emits one L/R sample pair per window with a strobe, for the audio output path.
// PARAMETERS
//  DECIM  32  CE ticks per output sample; power of two, 2..256
//  DC_K   8   DC-blocker pole shift, 4..12 (used only with PSG_DCBLOCK_EN)
// PORTS
//  CLK          in   1   global clock
//  RESET        in   1   synchronous, active-high reset
//  CE           in   1   PSG clock enable (same strobe that drives the PSG core)
//  STEREO_MODE  in   2   0 mono, 1 ABC, 2 ACB, 3 = mono
//  MUTE         in   1   forces the mix term to 0 for the current tick
//  CHANNEL_A    in   8   PSG channel A level (unsigned)
//  CHANNEL_B    in   8   PSG channel B level
//  CHANNEL_C    in   8   PSG channel C level
//  AUDIO_L      out  16  left sample (format per CONFIGURATION)
//  AUDIO_R      out  16  right sample
//  SAMPLE_STB   out  1   one-CLK pulse: AUDIO_L/R updated this cycle
// BEHAVIOUR
//  - Clock/reset: single clock CLK; RESET is synchronous and active-high.
//  - Reset: accumulators, tick counter, AUDIO_L/R, SAMPLE_STB and DC state all 0. Partial window discarded.
//  - Activity only on cycles with CE=1. No CE means no state change, except SAMPLE_STB clears to 0.
//  - Per CE tick, 10-bit mix (max 765):
//    - mono: L = R = A+B+C
//    - ABC: L = 2A+B, R = 2C+B
//    - ACB: L = 2A+C, R = 2B+C
//    - MUTE=1: L = R = 0
//  - STEREO_MODE and MUTE are sampled every CE. A mode change mid-window does not restart the window.
//  - Accumulator width: 10+log2(DECIM) bits per side; it cannot overflow.
//  - Tick counter runs 0..DECIM-1. On the CE where it equals DECIM-1:
//    - mean = (acc + current mix) >> log2(DECIM)
//    - acc reloads to 0 and the counter wraps to 0
//  - Output registered; SAMPLE_STB high exactly one CLK. Latency from final-window CE:
//    1 CLK (2 CLK with DC blocker).
//  - CE on the SAMPLE_STB cycle is counted normally; back-to-back windows lose no ticks.
//  - RESET during SAMPLE_STB: reset wins, so STB=0 on the next cycle.
// CONFIGURATION
//  PSG_DCBLOCK_EN undefined:
//    - AUDIO = {mean, 6'b0}, unsigned, range 0..0xBF40
//  PSG_DCBLOCK_EN defined:
//    - x = {mean, 5'b0} signed (max 24480)
//    - y = x - x_prev + y_prev - (y_prev >>> DC_K), computed at 18 bits
//    - output saturated to signed 16 (two's complement); x_prev/y_prev update only on window end
// STRUCTURE
//  - Package psg_audio_pkg: stereo_mode_e enum, MIX_W=10, OUT_W=16, function psg_mix(mode, a, b, c)
//    returning {L, R}.
//  - Sub-module psg_dc_blocker (one per side, generated only under PSG_DCBLOCK_EN).
//    Interface: CLK, RESET, in_stb, x, out_stb, y.
//  - Top holds the tick counter, accumulators and output registers.
// TESTING (DECIM=32, CE every 4 CLK unless noted)
//  1. Mono, A=B=C=0xFF, 32 CE -> single SAMPLE_STB, L = R = 0xBF40; next STB exactly 32 CE later.
//  2. ABC, A=0x80, B=0x00, C=0x10 -> L=0x4000, R=0x0800. Switch to ACB -> L=0x4400, R=0x0400.
//  3. Mono, A=B=C=0x40, MUTE high for 16 of 32 CE -> L = R = 0x1800.
//  4. RESET after 10 CE -> outputs 0, no STB until 32 further CE.
//     CE held low 100 CLK mid-window -> no STB, window completes later.
//  5. CE every CLK -> STB every 32 CLK, never two adjacent; verify no tick lost across the window boundary.
//  6. PSG_DCBLOCK_EN, DC_K=8, mono, A=B=C=0xFF from reset -> first sample 0x5FA0, second 0x5F41,
//     decays monotonically toward 0. Step to 0 -> negative excursion, no wrap (saturation holds).

Source files
------------

// File: rtl/psg_audio_pkg.sv
// Shared types and the per-tick stereo mix function for the PSG audio mixer.
package psg_audio_pkg;

    localparam int unsigned CH_W  = 8;
    localparam int unsigned MIX_W = 10;
    localparam int unsigned OUT_W = 16;

    typedef enum logic [1:0] {
        MODE_MONO     = 2'd0,
        MODE_ABC      = 2'd1,
        MODE_ACB      = 2'd2,
        MODE_MONO_ALT = 2'd3
    } stereo_mode_e;

    // Returns {L, R}; the centre channel gets weight 1, the panned ones weight 2.
    function automatic logic [2*MIX_W-1:0] psg_mix(input stereo_mode_e mode,
                                                    input logic [CH_W-1:0] a,
                                                    input logic [CH_W-1:0] b,
                                                    input logic [CH_W-1:0] c);
        logic [MIX_W-1:0] ea;
        logic [MIX_W-1:0] eb;
        logic [MIX_W-1:0] ec;
        logic [MIX_W-1:0] l;
        logic [MIX_W-1:0] r;
        ea = MIX_W'(a);
        eb = MIX_W'(b);
        ec = MIX_W'(c);
        case (mode)
            MODE_ABC: begin
                l = (ea << 1) + eb;
                r = (ec << 1) + eb;
            end
            MODE_ACB: begin
                l = (ea << 1) + ec;
                r = (eb << 1) + ec;
            end
            default: begin
                l = ea + eb + ec;
                r = l;
            end
        endcase
        return {l, r};
    endfunction

endpackage

// File: rtl/psg_dc_blocker.sv
// One-pole DC blocker applied once per output sample; only built with PSG_DCBLOCK_EN.
`ifdef PSG_DCBLOCK_EN
module psg_dc_blocker
    import psg_audio_pkg::*;
#(
    parameter int unsigned DC_K = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_stb,
    input  logic [OUT_W-1:0] x,
    output logic             out_stb,
    output logic [OUT_W-1:0] y
);

    localparam int unsigned CALC_W = 18;
    localparam int unsigned EXT_W  = CALC_W - OUT_W;

    logic [OUT_W-1:0]         x_prev_q, x_prev_d;
    logic [OUT_W-1:0]         y_q, y_d;
    logic                     stb_q, stb_d;
    logic signed [CALC_W-1:0] x_e, xp_e, yp_e, y_calc;

    // The saturated output doubles as y_prev for the next sample.
    always_comb begin
        x_prev_d = x_prev_q;
        y_d      = y_q;
        stb_d    = in_stb;
        x_e      = $signed({{EXT_W{x[OUT_W-1]}}, x});
        xp_e     = $signed({{EXT_W{x_prev_q[OUT_W-1]}}, x_prev_q});
        yp_e     = $signed({{EXT_W{y_q[OUT_W-1]}}, y_q});
        y_calc   = x_e - xp_e + yp_e - (yp_e >>> DC_K);
        if (in_stb) begin
            x_prev_d = x;
            if (y_calc[CALC_W-1:OUT_W-1] == '0 || y_calc[CALC_W-1:OUT_W-1] == '1) begin
                y_d = y_calc[OUT_W-1:0];
            end else if (y_calc[CALC_W-1]) begin
                y_d = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                y_d = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_prev_q <= '0;
            y_q      <= '0;
            stb_q    <= 1'b0;
        end else begin
            x_prev_q <= x_prev_d;
            y_q      <= y_d;
            stb_q    <= stb_d;
        end
    end

    assign y       = y_q;
    assign out_stb = stb_q;

endmodule
`endif

// File: rtl/psg_audio_mixer.sv
// PSG stereo mixer with box-filter decimation over DECIM clock-enable ticks.
// Define PSG_DCBLOCK_EN to add a signed DC-blocking stage on each output side.
module psg_audio_mixer
    import psg_audio_pkg::*;
#(
    parameter int unsigned DECIM = 32,
    parameter int unsigned DC_K  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic [1:0]       STEREO_MODE,
    input  logic             MUTE,
    input  logic [CH_W-1:0]  CHANNEL_A,
    input  logic [CH_W-1:0]  CHANNEL_B,
    input  logic [CH_W-1:0]  CHANNEL_C,
    output logic [OUT_W-1:0] AUDIO_L,
    output logic [OUT_W-1:0] AUDIO_R,
    output logic             SAMPLE_STB
);

    localparam int unsigned SHIFT = $clog2(DECIM);
    localparam int unsigned CNT_W = SHIFT;
    localparam int unsigned ACC_W = MIX_W + SHIFT;

    if (DECIM < 2 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("DECIM must be a power of two in 2..256");
    end
    if (DC_K < 4 || DC_K > 12) begin : g_bad_dck
        $error("DC_K must be in 4..12");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [OUT_W-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
    logic               out_stb_q, out_stb_d;
    logic [2*MIX_W-1:0] mix_lr;
    logic [MIX_W-1:0]   mix_l, mix_r, mean_l, mean_r;
    logic [ACC_W-1:0]   sum_l, sum_r;
    logic               last_tick;

    // The final tick of a window is folded into the mean rather than the accumulator.
    always_comb begin
        cnt_d     = cnt_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        out_stb_d = 1'b0;
        mix_lr    = MUTE ? '0 : psg_mix(stereo_mode_e'(STEREO_MODE), CHANNEL_A, CHANNEL_B, CHANNEL_C);
        mix_l     = mix_lr[2*MIX_W-1:MIX_W];
        mix_r     = mix_lr[MIX_W-1:0];
        sum_l     = acc_l_q + ACC_W'(mix_l);
        sum_r     = acc_r_q + ACC_W'(mix_r);
        mean_l    = MIX_W'(sum_l >> SHIFT);
        mean_r    = MIX_W'(sum_r >> SHIFT);
        last_tick = (cnt_q == CNT_W'(DECIM - 1));
        if (CE) begin
            if (last_tick) begin
                cnt_d     = '0;
                acc_l_d   = '0;
                acc_r_d   = '0;
                out_stb_d = 1'b1;
`ifdef PSG_DCBLOCK_EN
                out_l_d   = {1'b0, mean_l, 5'b0};
                out_r_d   = {1'b0, mean_r, 5'b0};
`else
                out_l_d   = {mean_l, 6'b0};
                out_r_d   = {mean_r, 6'b0};
`endif
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                acc_l_d = sum_l;
                acc_r_d = sum_r;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            out_stb_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            out_stb_q <= out_stb_d;
        end
    end

`ifdef PSG_DCBLOCK_EN
    logic stb_l, stb_r;

    psg_dc_blocker #(.DC_K(DC_K)) u_dc_l (
        .CLK     (CLK),
        .RESET   (RESET),
        .in_stb  (out_stb_q),
        .x       (out_l_q),
        .out_stb (stb_l),
        .y       (AUDIO_L)
    );

    psg_dc_blocker #(.DC_K(DC_K)) u_dc_r (
        .CLK     (CLK),
        .RESET   (RESET),
        .in_stb  (out_stb_q),
        .x       (out_r_q),
        .out_stb (stb_r),
        .y       (AUDIO_R)
    );

    assign SAMPLE_STB = stb_l & stb_r;
`else
    assign AUDIO_L    = out_l_q;
    assign AUDIO_R    = out_r_q;
    assign SAMPLE_STB = out_stb_q;
`endif

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Directed bench for psg_audio_mixer (DECIM=32); DC-blocker checks only with PSG_DCBLOCK_EN.
module tb_psg_audio_mixer;

    localparam int DECIM = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CE;
    logic [1:0]  STEREO_MODE;
    logic        MUTE;
    logic [7:0]  CHANNEL_A, CHANNEL_B, CHANNEL_C;
    logic [15:0] AUDIO_L, AUDIO_R;
    logic        SAMPLE_STB;

    always #5 CLK = ~CLK;

    psg_audio_mixer #(.DECIM(DECIM), .DC_K(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CE          (CE),
        .STEREO_MODE (STEREO_MODE),
        .MUTE        (MUTE),
        .CHANNEL_A   (CHANNEL_A),
        .CHANNEL_B   (CHANNEL_B),
        .CHANNEL_C   (CHANNEL_C),
        .AUDIO_L     (AUDIO_L),
        .AUDIO_R     (AUDIO_R),
        .SAMPLE_STB  (SAMPLE_STB)
    );

    int checks = 0;
    int errors = 0;
    int ce_cnt = 0;
    int adjacent = 0;
    logic prev_stb = 1'b0;
    logic [15:0] q_l[$];
    logic [15:0] q_r[$];
    int          q_ce[$];

    // CE ticks seen by the DUT since the last reset.
    always @(posedge CLK) begin
        if (RESET) ce_cnt = 0;
        else if (CE) ce_cnt = ce_cnt + 1;
    end

    always @(negedge CLK) begin
        if (SAMPLE_STB) begin
            q_l.push_back(AUDIO_L);
            q_r.push_back(AUDIO_R);
            q_ce.push_back(ce_cnt);
            if (prev_stb) adjacent = adjacent + 1;
        end
        prev_stb = SAMPLE_STB;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        q_l.delete();
        q_r.delete();
        q_ce.delete();
    endtask

    task automatic tick(input int spacing);
        CE = 1'b1;
        @(posedge CLK);
        #1;
        CE = 1'b0;
        repeat (spacing - 1) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic window(input int n, input int spacing);
        repeat (n) tick(spacing);
    endtask

    task automatic set_in(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        STEREO_MODE = m;
        CHANNEL_A   = a;
        CHANNEL_B   = b;
        CHANNEL_C   = c;
    endtask

    task automatic expect_stb(input string name, input logic [15:0] exp_l, input logic [15:0] exp_r);
        chk({name, "_stb_count"}, q_l.size(), 1);
        if (q_l.size() > 0) begin
            chk({name, "_L"}, int'(q_l[0]), int'(exp_l));
            chk({name, "_R"}, int'(q_r[0]), int'(exp_r));
            chk({name, "_window_align"}, q_ce[0] % DECIM, 0);
        end
        clear_log();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset_L", int'(AUDIO_L), 0);
        chk("reset_R", int'(AUDIO_R), 0);
        chk("reset_stb", int'(SAMPLE_STB), 0);
        RESET = 1'b0;
    endtask

`ifndef PSG_DCBLOCK_EN
    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a, b, c;
        logic [15:0] exp_l, exp_r;
    } vec_t;
    vec_t vecs[7];
`else
    int xp_m = 0;
    int yp_m = 0;

    task automatic dc_model(input int x, output int y);
        y = x - xp_m + yp_m - (yp_m >>> 8);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        xp_m = x;
        yp_m = y;
    endtask
`endif

    initial begin
        RESET = 1'b1;
        CE    = 1'b0;
        MUTE  = 1'b0;
        set_in(2'd0, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        do_reset();
        clear_log();

`ifndef PSG_DCBLOCK_EN
        vecs[0] = '{2'd0, 8'hFF, 8'hFF, 8'hFF, 16'hBF40, 16'hBF40};
        vecs[1] = '{2'd1, 8'h80, 8'h00, 8'h10, 16'h4000, 16'h0800};
        vecs[2] = '{2'd2, 8'h80, 8'h00, 8'h10, 16'h4400, 16'h0400};
        vecs[3] = '{2'd3, 8'h01, 8'h02, 8'h03, 16'h0180, 16'h0180};
        vecs[4] = '{2'd1, 8'hFF, 8'hFF, 8'h00, 16'hBF40, 16'h3FC0};
        vecs[5] = '{2'd0, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
        vecs[6] = '{2'd2, 8'h00, 8'hFF, 8'hFF, 16'h3FC0, 16'hBF40};

        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c);
            window(DECIM, 4);
            expect_stb($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
        end

        // Half the window muted.
        set_in(2'd0, 8'h40, 8'h40, 8'h40);
        MUTE = 1'b1;
        window(16, 4);
        MUTE = 1'b0;
        window(16, 4);
        expect_stb("mute_half", 16'h1800, 16'h1800);

        // Mode switch mid-window keeps accumulating.
        set_in(2'd1, 8'h80, 8'h00, 8'h10);
        window(16, 4);
        set_in(2'd2, 8'h80, 8'h00, 8'h10);
        window(16, 4);
        expect_stb("mode_switch", 16'h4200, 16'h0600);

        // Reset discards a partial window.
        set_in(2'd0, 8'hFF, 8'hFF, 8'hFF);
        window(10, 4);
        do_reset();
        clear_log();
        set_in(2'd0, 8'h10, 8'h10, 8'h10);
        window(31, 4);
        chk("post_reset_no_early_stb", q_l.size(), 0);
        window(1, 4);
        expect_stb("post_reset", 16'h0C00, 16'h0C00);

        // Long CE gap mid-window.
        set_in(2'd0, 8'h20, 8'h20, 8'h20);
        window(16, 4);
        repeat (100) begin
            @(posedge CLK);
            #1;
        end
        chk("ce_gap_no_stb", q_l.size(), 0);
        window(16, 4);
        expect_stb("ce_gap", 16'h1800, 16'h1800);

        // Continuous CE with a ramp on A: any lost tick shifts both means.
        adjacent = 0;
        for (int k = 0; k < 2 * DECIM; k++) begin
            set_in(2'd0, 8'(k), 8'h00, 8'h00);
            tick(1);
        end
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("ramp_stb_count", q_l.size(), 2);
        if (q_l.size() == 2) begin
            chk("ramp_w0", int'(q_l[0]), 16'h03C0);
            chk("ramp_w1", int'(q_l[1]), 16'h0BC0);
            chk("ramp_spacing", q_ce[1] - q_ce[0], DECIM);
        end
        chk("ramp_no_adjacent", adjacent, 0);
        clear_log();

        // Strobe appears one CLK after the final CE; reset then kills it.
        set_in(2'd0, 8'hFF, 8'hFF, 8'hFF);
        window(DECIM, 1);
        chk("latency_stb", int'(SAMPLE_STB), 1);
        chk("latency_L", int'(AUDIO_L), 16'hBF40);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset_on_stb", int'(SAMPLE_STB), 0);
        chk("reset_on_stb_L", int'(AUDIO_L), 0);
        RESET = 1'b0;
        clear_log();
`else
        begin
            int y_exp;
            int y_prev;
            set_in(2'd0, 8'hFF, 8'hFF, 8'hFF);
            y_prev = 32768;
            for (int w = 0; w < 6; w++) begin
                dc_model(24480, y_exp);
                window(DECIM, 4);
                if (w == 0) chk("dc_first_lit", q_l.size() > 0 ? int'(q_l[0]) : -1, 16'h5FA0);
                if (w == 1) chk("dc_second_lit", q_l.size() > 0 ? int'(q_l[0]) : -1, 16'h5F41);
                if (q_l.size() > 0) begin
                    chk($sformatf("dc_decay_w%0d", w), int'($signed(q_l[0])) < y_prev ? 1 : 0, 1);
                    y_prev = int'($signed(q_l[0]));
                end
                expect_stb($sformatf("dc_up_w%0d", w), 16'(y_exp), 16'(y_exp));
            end
            set_in(2'd0, 8'h00, 8'h00, 8'h00);
            for (int w = 0; w < 4; w++) begin
                dc_model(0, y_exp);
                window(DECIM, 4);
                if (q_l.size() > 0) chk($sformatf("dc_neg_w%0d", w), int'(q_l[0][15]), 1);
                expect_stb($sformatf("dc_down_w%0d", w), 16'(y_exp), 16'(y_exp));
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
